// File: rtl/xy_write_arbiter.sv
// XY-memory write-port arbiter: accmov writebacks win, host writes queue in a FIFO,
// starvation guard forces a host slot. Optional counters under XY_ARB_STATS_EN.
module xy_write_arbiter #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 16,
    parameter int HOST_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_data,
    output logic              xy_we,
    output logic [ADDR_W-1:0] xy_waddr,
    output logic [DATA_W-1:0] xy_wdata,
    output logic              idle
`ifdef XY_ARB_STATS_EN
    ,
    output logic [31:0]       stat_host_writes,
    output logic [31:0]       stat_acc_writes,
    output logic [15:0]       stat_forced
`endif
);

    localparam int PTR_W    = $clog2(HOST_FIFO_DEPTH);
    localparam int CNT_W    = $clog2(HOST_FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ACC_PRI,
        HOST_FORCE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]   fifo_addr [HOST_FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [HOST_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;

    logic fifo_empty;
    logic push;
    logic pop;
    logic grant_acc;
    logic grant_host;

    assign fifo_empty = (count == '0);
    assign host_ready = (count != CNT_W'(HOST_FIFO_DEPTH));
    assign push       = host_valid & host_ready;
    assign pop        = grant_host;
    assign idle       = fifo_empty & ~xy_we;

    // Grant selection, starvation tracking and next state.
    always_comb begin
        state_next  = state;
        acc_ready   = 1'b1;
        grant_acc   = 1'b0;
        grant_host  = 1'b0;
        starve_next = starve_cnt;

        case (state)
            ACC_PRI: begin
                acc_ready = 1'b1;
                if (acc_valid) begin
                    grant_acc = 1'b1;
                end else if (!fifo_empty) begin
                    grant_host = 1'b1;
                end
            end
            HOST_FORCE: begin
                acc_ready  = 1'b0;
                grant_host = ~fifo_empty;
                state_next = ACC_PRI;
            end
            default: begin
                state_next = ACC_PRI;
            end
        endcase

        if (grant_host || fifo_empty) begin
            starve_next = '0;
        end else if (grant_acc && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_next = starve_cnt + 1'b1;
        end

        if ((state == ACC_PRI) && grant_acc && !fifo_empty &&
            (starve_next == STARVE_W'(STARVE_LIMIT))) begin
            state_next = HOST_FORCE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACC_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_addr;
            fifo_data[wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address and data hold their last values on idle cycles; only xy_we drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xy_we    <= 1'b0;
            xy_waddr <= '0;
            xy_wdata <= '0;
        end else begin
            xy_we <= grant_acc | grant_host;
            if (grant_acc) begin
                xy_waddr <= acc_addr;
                xy_wdata <= acc_data;
            end else if (grant_host) begin
                xy_waddr <= fifo_addr[rd_ptr];
                xy_wdata <= fifo_data[rd_ptr];
            end
        end
    end

`ifdef XY_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_host_writes <= '0;
            stat_acc_writes  <= '0;
            stat_forced      <= '0;
        end else begin
            if (grant_host) begin
                stat_host_writes <= stat_host_writes + 1'b1;
            end
            if (grant_acc) begin
                stat_acc_writes <= stat_acc_writes + 1'b1;
            end
            if ((state == ACC_PRI) && (state_next == HOST_FORCE)) begin
                stat_forced <= stat_forced + 1'b1;
            end
        end
    end
`endif

endmodule
